// File: rtl/stream_frame_writer_if.sv
// rtl/stream_frame_writer_if.sv - framed valid/ready stream bundle
//
// Purpose: carries one framed input stream into stream_frame_writer.
// Signals:
//   s_valid  beat valid (source)
//   s_ready  beat accepted when s_valid & s_ready (sink)
//   s_sop    first beat of frame (source)
//   s_eop    last beat of frame (source)
//   s_data   beat payload, DATAWIDTH bits (source)
interface stream_frame_writer_if #(
   parameter int DATAWIDTH = 8
);
   logic                 s_valid;
   logic                 s_ready;
   logic                 s_sop;
   logic                 s_eop;
   logic [DATAWIDTH-1:0] s_data;

   modport master (output s_valid, s_sop, s_eop, s_data, input s_ready);
   modport slave  (input s_valid, s_sop, s_eop, s_data, output s_ready);
endinterface

// File: rtl/stream_frame_writer.sv
// rtl/stream_frame_writer.sv - framed stream to async FIFO write-side front end
//
// Purpose: checks frame protocol and length of the incoming stream and drives
// the FIFO controller write command port so that only complete, well-formed
// frames are committed; everything else is aborted and counted.
// Ports:
//   clk, rst_n   write clock, asynchronous active-low reset
//   s            framed input stream (slave side)
//   w_ctrl       FIFO command: 0 NOP, 1 WRITE, 2 COMMIT, 3 ABORT (registered)
//   w_data       RAM write data, valid with WRITE (registered)
//   w_full       FIFO full, sampled at the accepting edge
//   w_error      FIFO controller error
//   last_len     length of the last committed frame
//   frm_cnt      committed frames, wraps
//   drop_cnt     aborted/discarded frames, saturates
//   err          one-cycle pulse on a protocol error
module stream_frame_writer #(
   parameter int DATAWIDTH = 8,
   parameter int ADDRWIDTH = 6,
   parameter int MAXFRAME  = 44,
   parameter int MINFRAME  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   stream_frame_writer_if.slave s,
   output logic [2:0]           w_ctrl,
   output logic [DATAWIDTH-1:0] w_data,
   input  logic                 w_full,
   input  logic                 w_error,
   output logic [ADDRWIDTH:0]   last_len,
   output logic [15:0]          frm_cnt,
   output logic [15:0]          drop_cnt,
   output logic                 err
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RECV = 3'd1;
   localparam logic [2:0] S_DROP = 3'd2;
   localparam logic [2:0] S_CMIT = 3'd3;
   localparam logic [2:0] S_ABRT = 3'd4;

   localparam logic [2:0] C_NOP    = 3'd0;
   localparam logic [2:0] C_WRITE  = 3'd1;
   localparam logic [2:0] C_COMMIT = 3'd2;
   localparam logic [2:0] C_ABORT  = 3'd3;

   localparam logic [ADDRWIDTH:0] MAX_LEN = MAXFRAME[ADDRWIDTH:0];
   localparam logic [ADDRWIDTH:0] MIN_LEN = MINFRAME[ADDRWIDTH:0];
   localparam logic [ADDRWIDTH:0] ONE_LEN = {{ADDRWIDTH{1'b0}}, 1'b1};

   logic [2:0]           state;
   logic [ADDRWIDTH:0]   len;
   logic [ADDRWIDTH:0]   len_inc;
   logic                 abrt_eop;   // aborting beat closed the frame: skip DROP
   logic                 abrt_pend;  // runt: ABORT deferred past its final WRITE
   logic                 accept;
   logic                 abort_now;
   logic                 abort_err;
   logic                 drop_evt;

   assign s.s_ready = (state == S_IDLE) || (state == S_RECV) || (state == S_DROP);
   assign accept    = s.s_valid & s.s_ready;
   assign len_inc   = len + ONE_LEN;

   // Abort decision in RECV. sop outranks FIFO trouble, which outranks
   // oversize; only sop and oversize count as protocol errors.
   always_comb begin
      abort_now = 1'b0;
      abort_err = 1'b0;
      drop_evt  = 1'b0;
      case (state)
         S_IDLE: drop_evt = accept & s.s_sop & s.s_eop & (MINFRAME != 1);
         S_RECV: begin
            if (accept) begin
               abort_now = s.s_sop | w_full | w_error | (len == MAX_LEN);
               abort_err = s.s_sop | (~w_full & ~w_error & (len == MAX_LEN));
            end else begin
               abort_now = w_error;
            end
            drop_evt = abort_now;
         end
         S_ABRT: drop_evt = abrt_pend;
         default: drop_evt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         len       <= '0;
         abrt_eop  <= 1'b0;
         abrt_pend <= 1'b0;
         w_ctrl    <= C_NOP;
         w_data    <= '0;
         last_len  <= '0;
         frm_cnt   <= '0;
         drop_cnt  <= '0;
         err       <= 1'b0;
      end else begin
         w_ctrl <= C_NOP;
         err    <= 1'b0;
         if (drop_evt && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (!s.s_sop) begin
                     err <= 1'b1;
                  end else if (!s.s_eop || (MINFRAME == 1)) begin
                     w_ctrl <= C_WRITE;
                     w_data <= s.s_data;
                     len    <= ONE_LEN;
                     state  <= s.s_eop ? S_CMIT : S_RECV;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            S_RECV: begin
               if (abort_now) begin
                  // ABORT goes out now, in the slot the discarded beat would have used
                  w_ctrl   <= C_ABORT;
                  err      <= abort_err;
                  abrt_eop <= accept & s.s_eop;
                  state    <= S_ABRT;
               end else if (accept) begin
                  w_ctrl <= C_WRITE;
                  w_data <= s.s_data;
                  len    <= len_inc;
                  if (s.s_eop) begin
                     if (len_inc >= MIN_LEN) begin
                        state <= S_CMIT;
                     end else begin
                        abrt_pend <= 1'b1;
                        abrt_eop  <= 1'b1;
                        state     <= S_ABRT;
                     end
                  end
               end
            end
            S_DROP: begin
               if (accept && s.s_eop) begin
                  state <= S_IDLE;
               end
            end
            S_CMIT: begin
               w_ctrl   <= C_COMMIT;
               last_len <= len;
               frm_cnt  <= frm_cnt + 16'd1;
               state    <= S_IDLE;
            end
            S_ABRT: begin
               if (abrt_pend) begin
                  w_ctrl    <= C_ABORT;
                  err       <= 1'b1;
                  abrt_pend <= 1'b0;
               end
               state <= abrt_eop ? S_IDLE : S_DROP;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
